// File: rtl/phase_freq_est.sv
// Phase-difference frequency estimator: wraps successive CORDIC angle deltas into
// (-pi, pi] and emits the floored mean of each block of 2^LOG2_N deltas.
module phase_freq_est #(
   parameter int LOG2_N      = 4,
   parameter int PI_CODE     = 804,
   parameter int TWO_PI_CODE = 1608
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] angle_in,
   input  logic        angle_valid,
   input  logic        sync_clr,
   output logic [15:0] freq_out,
   output logic        freq_valid,
   output logic        primed
);

   localparam int ACC_W = 17 + LOG2_N;
   localparam logic [15:0]        TWO_PI_U = 16'(TWO_PI_CODE);
   localparam logic signed [16:0] PI_S     = 17'(PI_CODE);
   localparam logic signed [16:0] TWO_PI_S = 17'(TWO_PI_CODE);
   localparam logic [LOG2_N-1:0]  CNT_LAST = '1;

   typedef enum logic {EMPTY, ACCUM} state_t;

   state_t state, state_nxt;

   logic [15:0]              a_p0;
   logic signed [16:0]       d_p0;
   logic signed [ACC_W-1:0]  acc_sum_p0;

   logic [15:0]              prev_p1;
   logic signed [ACC_W-1:0]  acc_p1;
   logic [LOG2_N-1:0]        cnt_p1;
   logic [15:0]              freq_p1;
   logic                     vld_p1;

   // Fold a raw difference back into (-pi, pi]; -pi itself becomes +pi.
   function automatic logic signed [16:0] wrap_delta(input logic signed [16:0] d);
      if (d > PI_S)
         return d - TWO_PI_S;
      else if (d <= -PI_S)
         return d + TWO_PI_S;
      else
         return d;
   endfunction

   function automatic logic [15:0] mean_of(input logic signed [ACC_W-1:0] s);
      return 16'(s >>> LOG2_N);
   endfunction

   // Stage p0: normalise the sample and form the wrapped delta
   assign a_p0       = (angle_in >= TWO_PI_U) ? angle_in - TWO_PI_U : angle_in;
   assign d_p0       = wrap_delta($signed({1'b0, a_p0}) - $signed({1'b0, prev_p1}));
   assign acc_sum_p0 = acc_p1 + {{LOG2_N{d_p0[16]}}, d_p0};

   always_ff @(posedge clk) begin
      if (rst)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (sync_clr)
         state_nxt = EMPTY;
      else if (angle_valid)
         state_nxt = ACCUM;
   end

   // Stage p1: accumulate and register the block mean
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_p1 <= '0;
         acc_p1  <= '0;
         cnt_p1  <= '0;
         freq_p1 <= '0;
         vld_p1  <= 1'b0;
      end else if (sync_clr) begin
         acc_p1 <= '0;
         cnt_p1 <= '0;
         vld_p1 <= 1'b0;
      end else if (angle_valid) begin
         prev_p1 <= a_p0;
         if (state == EMPTY) begin
            acc_p1 <= '0;
            cnt_p1 <= '0;
            vld_p1 <= 1'b0;
         end else if (cnt_p1 == CNT_LAST) begin
            freq_p1 <= mean_of(acc_sum_p0);
            vld_p1  <= 1'b1;
            acc_p1  <= '0;
            cnt_p1  <= '0;
         end else begin
            acc_p1 <= acc_sum_p0;
            cnt_p1 <= cnt_p1 + 1'b1;
            vld_p1 <= 1'b0;
         end
      end else begin
         vld_p1 <= 1'b0;
      end
   end

   assign freq_out   = freq_p1;
   assign freq_valid = vld_p1;
   assign primed     = (state == ACCUM);

endmodule

// File: tb/tb_phase_freq_est.sv
// Bench for phase_freq_est: directed test-plan sequences plus random traffic,
// every cycle compared against an arithmetic reference model.
module tb_phase_freq_est;

   localparam int N      = 16;
   localparam int PI_C   = 804;
   localparam int TWO_PI = 1608;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] angle_in = '0;
   logic        angle_valid = 1'b0;
   logic        sync_clr = 1'b0;
   logic [15:0] freq_out;
   logic        freq_valid;
   logic        primed;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   bit m_primed = 0;
   int m_prev   = 0;
   int m_deltas[$];
   int m_fout   = 0;
   bit m_fvld   = 0;

   always #5 clk = ~clk;

   phase_freq_est #(.LOG2_N(4), .PI_CODE(PI_C), .TWO_PI_CODE(TWO_PI)) dut (
      .clk(clk), .rst(rst), .angle_in(angle_in), .angle_valid(angle_valid),
      .sync_clr(sync_clr), .freq_out(freq_out), .freq_valid(freq_valid), .primed(primed)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, obs, obs, exp, exp, $time);
   endtask

   function automatic int floor_div(input int s, input int n);
      if (s >= 0) return s / n;
      return -((-s + n - 1) / n);
   endfunction

   function automatic int wrapped(input int d);
      int r = d;
      while (r > PI_C)   r -= TWO_PI;
      while (r <= -PI_C) r += TWO_PI;
      return r;
   endfunction

   task automatic model_edge(input bit v, input int ang, input bit clr, input bit r);
      int a, sum;
      m_fvld = 0;
      if (r) begin
         m_primed = 0; m_prev = 0; m_deltas.delete(); m_fout = 0;
      end else if (clr) begin
         m_primed = 0; m_deltas.delete();
      end else if (v) begin
         a = (ang >= TWO_PI) ? ang - TWO_PI : ang;
         if (m_primed) begin
            m_deltas.push_back(wrapped(a - m_prev));
            if (m_deltas.size() == N) begin
               sum = 0;
               foreach (m_deltas[i]) sum += m_deltas[i];
               m_fout = floor_div(sum, N) & 16'hFFFF;
               m_fvld = 1;
               m_deltas.delete();
            end
         end
         m_primed = 1;
         m_prev   = a;
      end
   endtask

   task automatic step(input bit v, input int ang, input bit clr, input bit r);
      angle_valid = v;
      angle_in    = 16'(ang);
      sync_clr    = clr;
      rst         = r;
      @(posedge clk);
      #1;
      model_edge(v, ang, clr, r);
      check("freq_valid", freq_valid, m_fvld);
      check("freq_out", freq_out, m_fout);
      check("primed", primed, m_primed);
      angle_valid = 0;
      sync_clr    = 0;
      rst         = 0;
   endtask

   task automatic run_seq(input int start, input int stride, input int count);
      for (int i = 0; i < count; i++)
         step(1, ((start + stride * i) % TWO_PI + TWO_PI) % TWO_PI, 0, 0);
   endtask

   initial begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("reset_fout", freq_out, 0);
      check("reset_primed", primed, 0);
      check("reset_fvld", freq_valid, 0);

      run_seq(500, 0, 17);
      check("const_pulse", freq_valid, 1);
      check("const_val", freq_out, 0);

      step(0, 0, 1, 0);
      run_seq(0, 10, 17);
      check("ramp_pos", freq_out, 10);

      step(0, 0, 1, 0);
      run_seq(1600, -20, 17);
      check("ramp_neg", freq_out, 16'hFFEC);

      step(0, 0, 1, 0);
      run_seq(1550, 100, 17);
      check("wrap", freq_out, 100);

      step(0, 0, 1, 0);
      for (int i = 0; i < 17; i++) step(1, (i % 2) ? 804 : 0, 0, 0);
      check("pi_edge", freq_out, 804);

      step(0, 0, 1, 0);
      for (int i = 0; i < 16; i++) step(1, 500, 0, 0);
      step(1, 499, 0, 0);
      check("floor_neg1", freq_out, 16'hFFFF);

      step(0, 0, 1, 0);
      step(1, 1608, 0, 0);
      run_seq(10, 10, 16);
      check("norm_2pi", freq_out, 10);

      step(0, 0, 1, 0);
      for (int i = 0; i < 17; i++) begin
         step(1, 5 * i, 0, 0);
         if (i < 16) step(0, 0, 0, 0);
      end
      check("gapped_pulse", freq_valid, 1);
      check("gapped_val", freq_out, 5);

      step(0, 0, 1, 0);
      run_seq(0, 7, 9);
      step(1, 63, 1, 0);
      check("clr_primed", primed, 0);
      check("clr_hold", freq_out, 5);
      run_seq(200, 3, 17);
      check("after_clr", freq_out, 3);
      run_seq(0, 7, 9);
      step(1, 63, 0, 1);
      check("rst_fout", freq_out, 0);
      check("rst_primed", primed, 0);

      for (int i = 0; i < 600; i++) begin
         int r = int'($urandom_range(0, 99));
         step(r < 75, int'($urandom_range(0, TWO_PI)), r == 99, 0);
      end
      // slow random ramps exercise non-zero means with wrap
      for (int k = 0; k < 6; k++) begin
         int base = int'($urandom_range(0, TWO_PI - 1));
         int st   = int'($urandom_range(0, 1600)) - 800;
         run_seq(base, st, 40);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: run did not complete, got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
